// File: rtl/rst_pkg.sv
// rtl/rst_pkg.sv - shared state encoding and width helper for the reset sequencer
package rst_pkg;

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  // Bits needed to index 'value' distinct codes, never less than one bit
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rst_sync_core.sv
// rtl/rst_sync_core.sv - asynchronous-assert, synchronous-release reset synchroniser
module rst_sync_core #(
  parameter int NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  output logic rst_synced
);

  logic [NUM_STAGES-1:0] chain;

  // Clear instantly on RST; shift ones in while RST is low
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      chain <= '0;
    end else begin
      chain <= {chain[NUM_STAGES-2:0], 1'b1};
    end
  end

  assign rst_synced = chain[NUM_STAGES-1];

endmodule

// File: rtl/rst_seq_sync.sv
// rtl/rst_seq_sync.sv - multi-channel reset synchroniser with staggered release and software resets
module rst_seq_sync
  import rst_pkg::*;
#(
  parameter int NUM_STAGES     = 2,
  parameter int NUM_CH         = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_CH-1:0] SW_RST_REQ,
  output logic [NUM_CH-1:0] SYNC_RST,
  output logic              RST_DONE
);

  localparam int MAX_CNT = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = clog2_min1(MAX_CNT + 1);
  localparam int IDX_W   = clog2_min1(NUM_CH);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);

  if (NUM_STAGES < 2) begin : g_bad_stages
    $error("rst_seq_sync: NUM_STAGES must be >= 2");
  end
  if (NUM_CH < 1) begin : g_bad_ch
    $error("rst_seq_sync: NUM_CH must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("rst_seq_sync: HOLD_CYCLES must be >= 1");
  end
  if (STAGGER_CYCLES < 1) begin : g_bad_stagger
    $error("rst_seq_sync: STAGGER_CYCLES must be >= 1");
  end

  logic             rst_synced;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] sw_cnt [NUM_CH];
  logic [CNT_W-1:0] sw_nxt [NUM_CH];
  logic             sw_busy_nxt;

  rst_sync_core #(
    .NUM_STAGES (NUM_STAGES)
  ) u_sync (
    .CLK        (CLK),
    .RST        (RST),
    .rst_synced (rst_synced)
  );

  // Next software-reset countdown per channel: a request reloads, otherwise count down to zero
  always_comb begin
    sw_busy_nxt = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      sw_nxt[i] = '0;
      if (SW_RST_REQ[i]) begin
        sw_nxt[i] = HOLD_LOAD;
      end else if (sw_cnt[i] != '0) begin
        sw_nxt[i] = sw_cnt[i] - 1'b1;
      end
      if (sw_nxt[i] != '0) begin
        sw_busy_nxt = 1'b1;
      end
    end
  end

  // Hold, staggered release and run-time software resets, all outputs registered
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_HOLD;
      cnt      <= '0;
      idx      <= '0;
      SYNC_RST <= '0;
      RST_DONE <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        sw_cnt[i] <= '0;
      end
    end else begin
      case (state)
        S_HOLD: begin
          if (rst_synced) begin
            if (cnt == HOLD_LAST) begin
              SYNC_RST[0] <= 1'b1;
              cnt         <= '0;
              idx         <= IDX_ONE;
              if (NUM_CH == 1) begin
                state    <= S_RUN;
                RST_DONE <= 1'b1;
              end else begin
                state <= S_RELEASE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_RELEASE: begin
          if (cnt == STAG_LAST) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (idx == IDX_W'(k)) begin
                SYNC_RST[k] <= 1'b1;
              end
            end
            cnt <= '0;
            if (idx == IDX_LAST) begin
              state    <= S_RUN;
              RST_DONE <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          for (int i = 0; i < NUM_CH; i++) begin
            sw_cnt[i]   <= sw_nxt[i];
            SYNC_RST[i] <= (sw_nxt[i] == '0);
          end
          RST_DONE <= ~sw_busy_nxt;
        end
        default: begin
          state    <= S_HOLD;
          cnt      <= '0;
          idx      <= '0;
          SYNC_RST <= '0;
          RST_DONE <= 1'b0;
        end
      endcase
    end
  end

endmodule
